// File: rtl/bcd_pkg.sv
// Purpose : shared digit constants, FSM state encoding and BCD helpers for the serial subtractor.
// Latency : n/a (declarations only).
// Backpres: n/a (declarations only).
package bcd_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [4:0] BCD_BASE = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    // A nibble is a legal decimal digit when it does not exceed 9.
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_cell.sv
// Purpose : one decimal digit of x + (9 - y) + cin with decimal correction.
// Latency : combinational, zero cycles.
// Backpres: none; pure function of its inputs.
//
// Ports:
//   x    in  4  addend digit (minuend digit, or 0 when complementing)
//   y    in  4  digit to nine's-complement (subtrahend or previous result digit)
//   cin  in  1  decimal carry in
//   d    out 4  corrected result digit, 0..9
//   cout out 1  decimal carry out
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] d,
    output logic               cout
);

    logic [DIGIT_W-1:0] nine_comp;
    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W:0]   sum_corr;

    // Inputs are already known to be legal digits, so the raw sum spans 0..19
    // and a single subtraction of ten is the only correction ever needed.
    assign nine_comp = BCD_MAX - y;
    assign sum       = {1'b0, x} + {1'b0, nine_comp} + {{DIGIT_W{1'b0}}, cin};
    assign sum_corr  = sum - BCD_BASE;

    always_comb begin
        if (sum >= BCD_BASE) begin
            d    = sum_corr[DIGIT_W-1:0];
            cout = 1'b1;
        end else begin
            d    = sum[DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule : bcd_digit_cell

// File: rtl/bcd_serial_subtractor.sv
// Purpose : digit-serial BCD A-B, LSD first, with a second serial pass producing sign-magnitude output.
// Latency : start-accept edge is cycle 0; done in cycle NDIG+1 (A>=B), 2*NDIG+1 (A<B), or 1 (illegal digit).
// Backpres: start is ignored while busy; results hold from done until the next accepted start.
//
// Ports:
//   clk   in  1       rising-edge clock
//   rst_n in  1       asynchronous active-low reset
//   start in  1       operation request, accepted only when busy=0
//   a     in  4*NDIG  minuend, packed BCD, digit 0 in bits [3:0]
//   b     in  4*NDIG  subtrahend, packed BCD
//   busy  out 1       operation in progress (SUB, COMP, DONE)
//   done  out 1       one-cycle pulse when diff/neg/err are valid
//   diff  out 4*NDIG  magnitude |A-B|, packed BCD
//   neg   out 1       A < B
//   err   out 1       an operand contained a digit greater than 9
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DIGIT_W*NDIG-1:0] a,
    input  logic [DIGIT_W*NDIG-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*NDIG-1:0] diff,
    output logic                    neg,
    output logic                    err
);

    localparam int                VEC_W = DIGIT_W * NDIG;
    localparam int                IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NDIG - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   a_q, a_d;
    logic [VEC_W-1:0]   b_q, b_d;
    logic [VEC_W-1:0]   diff_q, diff_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;

    logic [DIGIT_W-1:0] cell_x;
    logic [DIGIT_W-1:0] cell_y;
    logic [DIGIT_W-1:0] cell_d;
    logic               cell_cout;

    function automatic logic has_bad_digit(input logic [VEC_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd(v[i*DIGIT_W +: DIGIT_W])) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One shared cell: the subtract pass feeds (a, b), the complement pass
    // feeds (0, diff) so the result is ten's-complemented in place.
    always_comb begin
        if (state_q == COMP) begin
            cell_x = '0;
            cell_y = diff_q[idx_q*DIGIT_W +: DIGIT_W];
        end else begin
            cell_x = a_q[idx_q*DIGIT_W +: DIGIT_W];
            cell_y = b_q[idx_q*DIGIT_W +: DIGIT_W];
        end
    end

    bcd_digit_cell u_cell (
        .x    (cell_x),
        .y    (cell_y),
        .cin  (carry_q),
        .d    (cell_d),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        neg_d   = neg_q;
        err_d   = err_q;
        idx_d   = idx_q;
        carry_d = carry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    diff_d  = '0;
                    neg_d   = 1'b0;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    // Legality is judged on the live inputs so an illegal
                    // operand is flagged without spending a subtract pass.
                    if (has_bad_digit(a) || has_bad_digit(b)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SUB;
                    end
                end
            end

            SUB: begin
                diff_d[idx_q*DIGIT_W +: DIGIT_W] = cell_d;
                carry_d = cell_cout;
                if (idx_q == LAST) begin
                    idx_d = '0;
                    if (cell_cout) begin
                        state_d = DONE;
                    end else begin
                        // No final carry: the stored digits are the ten's
                        // complement of |A-B|, so undo it in a second pass.
                        neg_d   = 1'b1;
                        carry_d = 1'b1;
                        state_d = COMP;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            COMP: begin
                diff_d[idx_q*DIGIT_W +: DIGIT_W] = cell_d;
                carry_d = cell_cout;
                if (idx_q == LAST) begin
                    // The carry out of the top digit carries no information here.
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule : bcd_serial_subtractor
